multicycle_control: RTL and testbench

Multi-cycle control unit for the RISC-V core: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and write-back cycles, driving the shared-datapath control signals. It replaces the single-cycle opcode decoder. It adds a memory-ready handshake, JAL support, a sticky illegal-opcode trap and a retired-instruction counter. It sits between the instruction register and the datapath multiplexers, register file and memory.

---
 rtl/risc_v_ctrl_pkg.sv | 70 +++++++
 rtl/multicycle_control_decode.sv | 90 +++++++++
 rtl/multicycle_control.sv | 133 +++++++++++++
 tb/tb_multicycle_control.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/risc_v_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit and the datapath it steers.
package risc_v_ctrl_pkg;

    // Opcode field values
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    // ALU operation codes
    localparam logic [2:0] AluOpR      = 3'b000;
    localparam logic [2:0] AluOpILogic = 3'b001;
    localparam logic [2:0] AluOpAdd    = 3'b010;
    localparam logic [2:0] AluOpU      = 3'b100;
    localparam logic [2:0] AluOpBranch = 3'b101;

    // ALU operand A select
    localparam logic [1:0] SrcAPc   = 2'b00;
    localparam logic [1:0] SrcARs1  = 2'b01;
    localparam logic [1:0] SrcAZero = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBFour = 2'b01;
    localparam logic [1:0] SrcBImm  = 2'b10;

    // Register write-back source select
    localparam logic [1:0] WbAlu = 2'b00;
    localparam logic [1:0] WbMem = 2'b01;
    localparam logic [1:0] WbPc4 = 2'b10;

    typedef enum logic [3:0] {
        StReset    = 4'd0,
        StFetch    = 4'd1,
        StDecode   = 4'd2,
        StMemAddr  = 4'd3,
        StMemRead  = 4'd4,
        StMemWb    = 4'd5,
        StMemWrite = 4'd6,
        StExecR    = 4'd7,
        StExecI    = 4'd8,
        StExecU    = 4'd9,
        StAluWb    = 4'd10,
        StBranch   = 4'd11,
        StJal      = 4'd12,
        StTrap     = 4'd13
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       pc_src;
        logic       illegal;
    } ctrl_t;

    localparam int unsigned CtrlWidth = $bits(ctrl_t);

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational state -> control-vector decode for the multi-cycle control unit.
module multicycle_control_decode
    import risc_v_ctrl_pkg::*;
(
    input  logic [3:0]           state_i,
    input  logic                 mem_ready_i,
    output logic [CtrlWidth-1:0] ctrl_o
);

    ctrl_t ctrl;

    // Moore decode; only the fetch-cycle IR/PC loads look at the memory handshake
    always_comb begin
        ctrl = '0;
        unique case (state_e'(state_i))
            StFetch: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_a = SrcAPc;
                ctrl.alu_src_b = SrcBFour;
                ctrl.alu_op    = AluOpAdd;
                ctrl.ir_write  = mem_ready_i;
                ctrl.pc_write  = mem_ready_i;
            end
            StDecode: begin
                // Precompute the branch/JAL target into the ALU result register
                ctrl.alu_src_a = SrcAPc;
                ctrl.alu_src_b = SrcBImm;
                ctrl.alu_op    = AluOpAdd;
            end
            StMemAddr: begin
                ctrl.alu_src_a = SrcARs1;
                ctrl.alu_src_b = SrcBImm;
                ctrl.alu_op    = AluOpAdd;
            end
            StMemRead: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            StMemWb: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = WbMem;
            end
            StMemWrite: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            StExecR: begin
                ctrl.alu_src_a = SrcARs1;
                ctrl.alu_src_b = SrcBRs2;
                ctrl.alu_op    = AluOpR;
            end
            StExecI: begin
                ctrl.alu_src_a = SrcARs1;
                ctrl.alu_src_b = SrcBImm;
                ctrl.alu_op    = AluOpILogic;
            end
            StExecU: begin
                ctrl.alu_src_a = SrcAZero;
                ctrl.alu_src_b = SrcBImm;
                ctrl.alu_op    = AluOpU;
            end
            StAluWb: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = WbAlu;
            end
            StBranch: begin
                ctrl.alu_src_a = SrcARs1;
                ctrl.alu_src_b = SrcBRs2;
                ctrl.alu_op    = AluOpBranch;
                ctrl.branch    = 1'b1;
                ctrl.pc_src    = 1'b1;
            end
            StJal: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_src     = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = WbPc4;
            end
            StTrap: begin
                ctrl.illegal = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

    assign ctrl_o = ctrl;

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V control FSM: state register, next-state logic, retired counter.
module multicycle_control
    import risc_v_ctrl_pkg::*;
#(
    parameter int unsigned OP_WIDTH      = 7,
    parameter int unsigned ALU_OP_WIDTH  = 3,
    parameter int unsigned RET_CNT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [OP_WIDTH-1:0]      OP_i,
    input  logic                     Mem_Ready_i,
    output logic                     PC_Write_o,
    output logic                     Branch_o,
    output logic                     IorD_o,
    output logic                     Mem_Read_o,
    output logic                     Mem_Write_o,
    output logic                     IR_Write_o,
    output logic [1:0]               Mem_to_Reg_o,
    output logic                     Reg_Write_o,
    output logic [1:0]               ALU_Src_A_o,
    output logic [1:0]               ALU_Src_B_o,
    output logic [ALU_OP_WIDTH-1:0]  ALU_Op_o,
    output logic                     PC_Src_o,
    output logic                     Illegal_o,
    output logic [RET_CNT_WIDTH-1:0] Retired_o
);

    state_e                   state_q, state_d;
    logic                     retire;
    logic [RET_CNT_WIDTH-1:0] retired_q, retired_d;
    logic [CtrlWidth-1:0]     ctrl_vec;
    ctrl_t                    ctrl;

    // State register; reset acts immediately, no clock needed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StReset;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and retire strobe
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            StReset: state_d = StFetch;
            StFetch: begin
                if (Mem_Ready_i) state_d = StDecode;
            end
            StDecode: begin
                case (OP_i)
                    OP_WIDTH'(OpRType):  state_d = StExecR;
                    OP_WIDTH'(OpIType):  state_d = StExecI;
                    OP_WIDTH'(OpLui):    state_d = StExecU;
                    OP_WIDTH'(OpLoad):   state_d = StMemAddr;
                    OP_WIDTH'(OpStore):  state_d = StMemAddr;
                    OP_WIDTH'(OpBranch): state_d = StBranch;
                    OP_WIDTH'(OpJal):    state_d = StJal;
                    default:             state_d = StTrap;
                endcase
            end
            StMemAddr: begin
                // Only loads and stores reach here, so anything not a store is a load
                state_d = (OP_i == OP_WIDTH'(OpStore)) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                if (Mem_Ready_i) state_d = StMemWb;
            end
            StMemWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StMemWrite: begin
                if (Mem_Ready_i) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end
            end
            StExecR, StExecI, StExecU: state_d = StAluWb;
            StAluWb, StBranch, StJal: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StTrap:  state_d = StTrap;
            default: state_d = StReset;
        endcase
    end

    // Retired-instruction counter, wraps naturally at its width
    always_comb begin
        retired_d = retired_q;
        if (retire) retired_d = retired_q + RET_CNT_WIDTH'(1);
    end

    // Retired counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    multicycle_control_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (Mem_Ready_i),
        .ctrl_o      (ctrl_vec)
    );

    assign ctrl = ctrl_t'(ctrl_vec);

    // Output decode: unpack the control vector onto the datapath ports
    always_comb begin
        PC_Write_o   = ctrl.pc_write;
        Branch_o     = ctrl.branch;
        IorD_o       = ctrl.iord;
        Mem_Read_o   = ctrl.mem_read;
        Mem_Write_o  = ctrl.mem_write;
        IR_Write_o   = ctrl.ir_write;
        Mem_to_Reg_o = ctrl.mem_to_reg;
        Reg_Write_o  = ctrl.reg_write;
        ALU_Src_A_o  = ctrl.alu_src_a;
        ALU_Src_B_o  = ctrl.alu_src_b;
        ALU_Op_o     = ALU_OP_WIDTH'(ctrl.alu_op);
        PC_Src_o     = ctrl.pc_src;
        Illegal_o    = ctrl.illegal;
        Retired_o    = retired_q;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with hand-derived per-cycle control vectors.
module tb_multicycle_control;

    // Vector layout: pc_write branch iord mem_read mem_write ir_write
    //                mem_to_reg[1:0] reg_write src_a[1:0] src_b[1:0] alu_op[2:0] pc_src illegal
    localparam logic [17:0] VRst     = 18'b0_0_0_0_0_0_00_0_00_00_000_0_0;
    localparam logic [17:0] VFetchR  = 18'b1_0_0_1_0_1_00_0_00_01_010_0_0;
    localparam logic [17:0] VFetchW  = 18'b0_0_0_1_0_0_00_0_00_01_010_0_0;
    localparam logic [17:0] VDecode  = 18'b0_0_0_0_0_0_00_0_00_10_010_0_0;
    localparam logic [17:0] VMemAddr = 18'b0_0_0_0_0_0_00_0_01_10_010_0_0;
    localparam logic [17:0] VMemRd   = 18'b0_0_1_1_0_0_00_0_00_00_000_0_0;
    localparam logic [17:0] VMemWb   = 18'b0_0_0_0_0_0_01_1_00_00_000_0_0;
    localparam logic [17:0] VMemWr   = 18'b0_0_1_0_1_0_00_0_00_00_000_0_0;
    localparam logic [17:0] VExecR   = 18'b0_0_0_0_0_0_00_0_01_00_000_0_0;
    localparam logic [17:0] VExecI   = 18'b0_0_0_0_0_0_00_0_01_10_001_0_0;
    localparam logic [17:0] VExecU   = 18'b0_0_0_0_0_0_00_0_10_10_100_0_0;
    localparam logic [17:0] VAluWb   = 18'b0_0_0_0_0_0_00_1_00_00_000_0_0;
    localparam logic [17:0] VBranch  = 18'b0_1_0_0_0_0_00_0_01_00_101_1_0;
    localparam logic [17:0] VJal     = 18'b1_0_0_0_0_0_10_1_00_00_000_1_0;
    localparam logic [17:0] VTrap    = 18'b0_0_0_0_0_0_00_0_00_00_000_0_1;

    localparam logic [6:0] OpR   = 7'b0110011;
    localparam logic [6:0] OpI   = 7'b0010011;
    localparam logic [6:0] OpU   = 7'b0110111;
    localparam logic [6:0] OpLd  = 7'b0000011;
    localparam logic [6:0] OpSt  = 7'b0100011;
    localparam logic [6:0] OpBr  = 7'b1100011;
    localparam logic [6:0] OpJ   = 7'b1101111;
    localparam logic [6:0] OpBad = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic       mem_ready;
    logic       pc_write, branch, iord, mem_read, mem_write, ir_write, reg_write, pc_src, illegal;
    logic [1:0] mem_to_reg, src_a, src_b;
    logic [2:0] alu_op;
    logic [3:0] retired;
    logic [17:0] obs;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_control #(
        .OP_WIDTH      (7),
        .ALU_OP_WIDTH  (3),
        .RET_CNT_WIDTH (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .OP_i         (op),
        .Mem_Ready_i  (mem_ready),
        .PC_Write_o   (pc_write),
        .Branch_o     (branch),
        .IorD_o       (iord),
        .Mem_Read_o   (mem_read),
        .Mem_Write_o  (mem_write),
        .IR_Write_o   (ir_write),
        .Mem_to_Reg_o (mem_to_reg),
        .Reg_Write_o  (reg_write),
        .ALU_Src_A_o  (src_a),
        .ALU_Src_B_o  (src_b),
        .ALU_Op_o     (alu_op),
        .PC_Src_o     (pc_src),
        .Illegal_o    (illegal),
        .Retired_o    (retired)
    );

    assign obs = {pc_write, branch, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_write,
                  src_a, src_b, alu_op, pc_src, illegal};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drive ready for one cycle, check the control vector mid-cycle, advance to next cycle
    task automatic cyc(input logic rdy, input logic [17:0] exp, input string tag);
        mem_ready = rdy;
        #1;
        check(tag, 32'(obs), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    // Assert reset asynchronously, check it took effect, release mid-cycle
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        check({tag, "_vec"}, 32'(obs), 32'(VRst));
        check({tag, "_ret"}, 32'(retired), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(1'b1, VRst, {tag, "_rel"});
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b1;
        op        = OpR;
        #2;
        do_reset("por");

        // R-type, zero wait
        cyc(1'b1, VFetchR, "r_fetch");
        cyc(1'b1, VDecode, "r_dec");
        cyc(1'b1, VExecR,  "r_exec");
        cyc(1'b1, VAluWb,  "r_wb");
        check("r_ret", 32'(retired), 32'd1);

        // Load with three wait cycles in MEM_READ: 8 cycles fetch to fetch
        op = OpLd;
        cyc(1'b1, VFetchR,  "ld_fetch");
        cyc(1'b1, VDecode,  "ld_dec");
        cyc(1'b1, VMemAddr, "ld_addr");
        for (int i = 0; i < 3; i++) cyc(1'b0, VMemRd, "ld_rd_wait");
        cyc(1'b1, VMemRd,   "ld_rd");
        cyc(1'b1, VMemWb,   "ld_wb");
        check("ld_ret", 32'(retired), 32'd2);

        // Store with two wait cycles in FETCH
        op = OpSt;
        cyc(1'b0, VFetchW, "st_fetch_wait");
        cyc(1'b0, VFetchW, "st_fetch_wait");
        cyc(1'b1, VFetchR, "st_fetch");
        cyc(1'b1, VDecode, "st_dec");
        cyc(1'b1, VMemAddr, "st_addr");
        cyc(1'b0, VMemWr,  "st_wr_wait");
        cyc(1'b1, VMemWr,  "st_wr");
        check("st_ret", 32'(retired), 32'd3);

        // I-logic and U-type
        op = OpI;
        cyc(1'b1, VFetchR, "i_fetch");
        cyc(1'b0, VDecode, "i_dec");
        cyc(1'b0, VExecI,  "i_exec");
        cyc(1'b0, VAluWb,  "i_wb");
        op = OpU;
        cyc(1'b1, VFetchR, "u_fetch");
        cyc(1'b1, VDecode, "u_dec");
        cyc(1'b1, VExecU,  "u_exec");
        cyc(1'b1, VAluWb,  "u_wb");
        check("iu_ret", 32'(retired), 32'd5);

        // Branch then JAL back to back from a fresh reset
        do_reset("rst2");
        op = OpBr;
        cyc(1'b1, VFetchR, "br_fetch");
        cyc(1'b1, VDecode, "br_dec");
        cyc(1'b1, VBranch, "br_exec");
        op = OpJ;
        cyc(1'b1, VFetchR, "jal_fetch");
        cyc(1'b1, VDecode, "jal_dec");
        cyc(1'b1, VJal,    "jal_exec");
        check("brj_ret", 32'(retired), 32'd2);

        // Illegal opcode: absorbing trap, ready ignored
        do_reset("rst3");
        op = OpBad;
        cyc(1'b1, VFetchR, "trap_fetch");
        cyc(1'b1, VDecode, "trap_dec");
        for (int i = 0; i < 20; i++) cyc(1'(i % 2), VTrap, "trap_hold");
        do_reset("trap_clr");

        // 17 R-type instructions with a 4-bit counter wrap to 1
        op = OpR;
        for (int i = 0; i < 17; i++) begin
            cyc(1'b1, VFetchR, "wrap_fetch");
            cyc(1'b1, VDecode, "wrap_dec");
            cyc(1'b1, VExecR,  "wrap_exec");
            cyc(1'b1, VAluWb,  "wrap_wb");
            if (i == 15) check("wrap_ret16", 32'(retired), 32'd0);
        end
        check("wrap_ret17", 32'(retired), 32'd1);

        // Reset asserted in the middle of EXEC_R
        cyc(1'b1, VFetchR, "mid_fetch");
        cyc(1'b1, VDecode, "mid_dec");
        mem_ready = 1'b1;
        #1;
        check("mid_exec", 32'(obs), 32'(VExecR));
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_vec", 32'(obs), 32'(VRst));
        check("mid_rst_ret", 32'(retired), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
